muldiv_sequencer: RTL and testbench

//  Multi-cycle multiply/divide unit owning the HI/LO register pair. Sits beside the ALU in EX;

---
 rtl/muldiv_sequencer_pkg.sv | 11 +
 rtl/muldiv_sequencer_div_core.sv | 61 ++++++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding.
package muldiv_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MULT = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_FIX  = 2'd3;

endpackage

// File: rtl/muldiv_sequencer_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
// The sequencer handles operand signs, the sign fix-up and the special cases.
module muldiv_sequencer_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [IW-1:0]    iter_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Asserted during the cycle whose step produces the last quotient bit.
  assign done      = (iter_q == IW'(WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Load operands, then restore-or-keep one bit per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, so a reset mid-divide leaves no stale partial result.
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      iter_q <= '0;
    end else if (step) begin
      iter_q <= iter_q + 1'b1;
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls EX on any HI/LO
// access or new mult/div while an operation is in flight.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MULT_LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_read,
  input  logic             hilo_write,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;

  logic             accept;
  logic             div_load;
  logic             div_step;
  logic             div_done;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;

  assign busy   = (state != ST_IDLE);
  assign stall  = busy & (start | hilo_read | hilo_write);
  assign accept = (state == ST_IDLE) & start & ~flush;

  // Divider magnitudes come straight from the EX operands on the accept edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    a_mag = a;
    b_mag = b;
    if (!is_unsigned && a[WIDTH-1]) a_mag = '0 - a;
    if (!is_unsigned && b[WIDTH-1]) b_mag = '0 - b;
  end

  assign div_load = accept & op_div;
  assign div_step = (state == ST_DIV) & ~flush;

  muldiv_sequencer_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Full-width product of the latched operands, sign- or zero-extended.
  always_comb begin
    a_ext   = {{WIDTH{op_signed & op_a[WIDTH-1]}}, op_a};
    b_ext   = {{WIDTH{op_signed & op_b[WIDTH-1]}}, op_b};
    product = a_ext * b_ext;
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    quo_fix = div_quo;
    rem_fix = div_rem;
    if (op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1])) quo_fix = '0 - div_quo;
    if (op_signed && op_a[WIDTH-1])                   rem_fix = '0 - div_rem;
  end

  // Sequencer FSM plus the architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush) begin
            if (start) begin
              op_a      <= a;
              op_b      <= b;
              op_signed <= ~is_unsigned;
              if (op_div) begin
                state <= ST_DIV;
              end else begin
                state <= ST_MULT;
                cnt   <= CW'(MULT_LATENCY - 1);
              end
            end
            if (hilo_write) begin
              if (hilo_sel) hi <= wdata;
              else          lo <= wdata;
            end
          end
        end
        ST_MULT: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            hi    <= product[2*WIDTH-1:WIDTH];
            lo    <= product[WIDTH-1:0];
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (flush)         state <= ST_IDLE;
          else if (div_done) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!flush) begin
            if (op_b == '0) begin
              hi <= op_a;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected {hi,lo}
// results, pushed on issue and popped when busy drops.
module tb_muldiv_sequencer;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, op_div, is_unsigned, hilo_read, hilo_write, hilo_sel, flush;
  logic [W-1:0]  a, b, wdata;
  logic          busy, stall;
  logic [W-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  muldiv_sequencer #(.WIDTH(W), .MULT_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_div      (op_div),
    .is_unsigned (is_unsigned),
    .a           (a),
    .b           (b),
    .hilo_read   (hilo_read),
    .hilo_write  (hilo_write),
    .hilo_sel    (hilo_sel),
    .wdata       (wdata),
    .flush       (flush),
    .busy        (busy),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result {hi,lo} computed with wide integer arithmetic.
  function automatic logic [63:0] model(input logic d, input logic u,
                                        input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    if (!d) begin
      if (u) p = {32'b0, x} * {32'b0, y};
      else   p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (u) begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
    q = sx / sy;
    r = sx % sy;
    p = {r[31:0], q[31:0]};
    return p;
  endfunction

  task automatic drive_op(input logic d, input logic u, input logic [31:0] x, input logic [31:0] y);
    op_div = d; is_unsigned = u; a = x; b = y; start = 1'b1;
  endtask

  // Called at the negedge after the accept edge; counts busy cycles and stall
  // behaviour, then compares HI/LO against the scoreboard head.
  task automatic wait_done(input string tag, input int exp_cycles, input logic exp_stall);
    int n = 0;
    int stalls = 0;
    int guard = 0;
    logic [63:0] exp;
    while (busy && guard < 200) begin
      n++;
      #1;
      if (stall) stalls++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_timeout"}, 64'(guard < 200), 64'd1);
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
    check({tag, "_stall_cycles"}, 64'(stalls), exp_stall ? 64'(n) : 64'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb.pop_front();
      check({tag, "_hilo"}, {hi, lo}, exp);
    end
  endtask

  task automatic issue(input string tag, input logic d, input logic u,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input logic read_during);
    @(negedge clk);
    drive_op(d, u, x, y);
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    hilo_read = read_during;
    wait_done(tag, d ? W + 1 : LAT, read_during);
    hilo_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; op_div = 0; is_unsigned = 0; a = 0; b = 0;
    hilo_read = 0; hilo_write = 0; hilo_sel = 0; wdata = 0; flush = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hi",    64'(hi),    64'd0);
    check("rst_lo",    64'(lo),    64'd0);

    issue("multu", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 1'b0);
    issue("mult",  1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0);
    issue("div",   1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    issue("divu0", 1'b1, 1'b1, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, 1'b0);
    issue("div_ovf_mfhi", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b1);
    check("post_div_stall", 64'(stall), 64'd0);
    issue("div_s0", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 1'b0);

    // MTLO / MTHI in IDLE.
    @(negedge clk);
    hilo_write = 1'b1; hilo_sel = 1'b0; wdata = 32'h0000_1234;
    #1 check("mtlo_stall", 64'(stall), 64'd0);
    @(negedge clk);
    hilo_write = 1'b1; hilo_sel = 1'b1; wdata = 32'hAAAA_5555;
    check("mtlo_lo", 64'(lo), 64'h1234);
    @(negedge clk);
    hilo_write = 1'b0;
    check("mthi_hi", 64'(hi), 64'hAAAA_5555);
    check("mthi_lo_kept", 64'(lo), 64'h1234);

    // Flush with start in IDLE: start ignored.
    start = 1'b1; op_div = 1'b0; a = 32'd3; b = 32'd3; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);

    // Flush with hilo_write: write ignored.
    hilo_write = 1'b1; hilo_sel = 1'b0; wdata = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    hilo_write = 1'b0; flush = 1'b0;
    check("flush_write_lo", 64'(lo), 64'h1234);

    // Flush around cycle 10 of a divide: back to IDLE, HI/LO untouched.
    drive_op(1'b1, 1'b1, 32'd1000, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("flush_div_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_busy", 64'(busy), 64'd0);
    check("flush_div_hilo", {hi, lo}, {32'hAAAA_5555, 32'h0000_1234});
    repeat (3) @(negedge clk);
    check("flush_div_hilo_later", {hi, lo}, {32'hAAAA_5555, 32'h0000_1234});

    // Back-to-back MULT: second start is held and stalls until the first finishes.
    @(negedge clk);
    drive_op(1'b0, 1'b0, 32'd100, 32'hFFFF_FFFE);
    sb.push_back(model(1'b0, 1'b0, 32'd100, 32'hFFFF_FFFE));
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0000_1000; is_unsigned = 1'b1;
    sb.push_back(model(1'b0, 1'b1, 32'h1234_5678, 32'h0000_1000));
    wait_done("b2b_first", LAT, 1'b1);
    #1 check("b2b_release_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second", LAT, 1'b0);

    // Random mix through the scoreboard, including zero divisors.
    for (int i = 0; i < 16; i++) begin
      logic d, u;
      logic [31:0] x, y;
      d = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 3) y = 32'd1;
      issue("rand", d, u, x, y, model(d, u, x, y), 1'($urandom_range(0, 1)));
    end

    // Reset mid-MULT: everything back to reset values immediately.
    @(negedge clk);
    drive_op(1'b0, 1'b1, 32'd9, 32'd9);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_mult_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check("rst_mid_hilo_later", {hi, lo}, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
